// File: rtl/multi_channel_sym_pwm.sv
// Centre-aligned N-channel complementary PWM with shared up/down carrier,
// runtime deadtime, shadowed period/duty, latched fault trip and override.
module multi_channel_sym_pwm #(
  parameter int CHANNELS      = 3,
  parameter int WIDTH         = 16,
  parameter int DT_WIDTH      = 8,
  parameter int LOAD_MODE     = 0,
  parameter int NEGATE_OUTPUT = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [WIDTH-1:0]        period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic [DT_WIDTH-1:0]     deadtime_i,
  input  logic [2*CHANNELS-1:0]   override_i,
  input  logic                    fault_i,
  input  logic                    fault_clear_i,
  output logic [2*CHANNELS-1:0]   PWM_o,
  output logic                    sync_o,
  output logic [WIDTH-1:0]        counter_o,
  output logic                    fault_o
);

  logic [WIDTH-1:0]    cnt;
  logic                dir;
  logic [WIDTH-1:0]    period_r;
  logic [WIDTH-1:0]    period_ld;
  logic [DT_WIDTH-1:0] dt_r;
  logic [WIDTH-1:0]    duty_r [CHANNELS];
  logic [DT_WIDTH-1:0] dt_cnt [CHANNELS];
  logic [DT_WIDTH-1:0] dt_n   [CHANNELS];
  logic [CHANNELS-1:0] ref_c;
  logic [CHANNELS-1:0] ref_q;
  logic [CHANNELS-1:0] ref_prev;
  logic [CHANNELS-1:0] hi_d;
  logic [CHANNELS-1:0] lo_d;
  logic [2*CHANNELS-1:0] pwm_d;
  logic [2*CHANNELS-1:0] pwm_q;
  logic                valley;
  logic                peak;
  logic                up;
  logic                gen_en;
  logic                fault_d;

  // Carrier decode: slope direction and shadow-load points.
  always_comb begin
    valley    = (cnt == '0);
    peak      = (cnt == period_r);
    up        = valley | (dir & (cnt < period_r));
    period_ld = (period_i < WIDTH'(2)) ? WIDTH'(2) : period_i;
  end

  // Triangle carrier plus period/deadtime shadows loaded at the valley.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      dir      <= 1'b1;
      period_r <= WIDTH'(2);
      dt_r     <= '0;
    end else begin
      cnt <= up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
      dir <= up;
      if (valley) begin
        period_r <= period_ld;
        dt_r     <= deadtime_i;
      end
    end
  end

  // Duty shadows: valley always, peak too when double-update is chosen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < CHANNELS; k++) duty_r[k] <= '0;
    end else if (valley || (LOAD_MODE != 0 && peak)) begin
      for (int k = 0; k < CHANNELS; k++)
        duty_r[k] <= duty_i[k*WIDTH +: WIDTH];
    end
  end

  // Down-slope compare is inclusive so the pulse is exactly 2*duty clocks.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++)
      ref_c[k] = up ? (duty_r[k] > cnt) : (duty_r[k] >= cnt);
  end

  // Deadtime: edges blank both sides, new side follows dt_r+1 clocks later.
  always_comb begin
    gen_en = enable_i & ~fault_o;
    for (int k = 0; k < CHANNELS; k++) begin
      dt_n[k] = dt_cnt[k];
      hi_d[k] = 1'b0;
      lo_d[k] = 1'b0;
      if (!gen_en) begin
        dt_n[k] = dt_r;
      end else if (ref_q[k] != ref_prev[k]) begin
        dt_n[k] = dt_r;
        if (dt_r == '0) begin
          hi_d[k] = ref_q[k];
          lo_d[k] = ~ref_q[k];
        end
      end else begin
        if (dt_cnt[k] != '0) dt_n[k] = dt_cnt[k] - DT_WIDTH'(1);
        if (dt_cnt[k] <= DT_WIDTH'(1)) begin
          hi_d[k] = ref_q[k];
          lo_d[k] = ~ref_q[k];
        end
      end
    end
  end

  // Fault beats override; override pair 11 locks both sides off.
  always_comb begin
    fault_d = fault_i | (fault_o & ~fault_clear_i);
    pwm_d   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (fault_d)
        pwm_d[2*k +: 2] = 2'b00;
      else if (override_i[2*k +: 2] == 2'b11)
        pwm_d[2*k +: 2] = 2'b00;
      else if (override_i[2*k +: 2] != 2'b00)
        pwm_d[2*k +: 2] = override_i[2*k +: 2];
      else
        pwm_d[2*k +: 2] = {lo_d[k], hi_d[k]};
    end
  end

  // Reference, edge history, deadtime counters, fault latch and pins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q    <= '0;
      ref_prev <= '0;
      pwm_q    <= '0;
      fault_o  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) dt_cnt[k] <= '0;
    end else begin
      ref_q    <= ref_c;
      ref_prev <= ref_q;
      pwm_q    <= pwm_d;
      fault_o  <= fault_d;
      for (int k = 0; k < CHANNELS; k++) dt_cnt[k] <= dt_n[k];
    end
  end

  // Pin polarity and status outputs.
  always_comb begin
    PWM_o     = (NEGATE_OUTPUT != 0) ? ~pwm_q : pwm_q;
    sync_o    = valley & rst_ni;
    counter_o = cnt;
  end

endmodule

// File: tb/tb_multi_channel_sym_pwm.sv
// Directed bench for multi_channel_sym_pwm: one default instance and one
// with peak reload and active-low pins, both on the same stimulus.
module tb_multi_channel_sym_pwm;
  localparam int CH = 3;
  localparam int W  = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic fault = 1'b0;
  logic fclr = 1'b0;
  logic [W-1:0] period = 16'd100;
  logic [CH*W-1:0] duty = {16'd200, 16'd0, 16'd50};
  logic [DW-1:0] dt = 8'd0;
  logic [2*CH-1:0] ovr = '0;

  logic [2*CH-1:0] pwm_a, pwm_b;
  logic sync_a, sync_b, flt_a, flt_b;
  logic [W-1:0] cnt_a, cnt_b;

  int n_assert = 0;
  int n_fail = 0;
  int hi0, lo0, off0, both0, hi1, lo1, hi2, lo2, hib, syncs;
  int k;

  multi_channel_sym_pwm #(
    .CHANNELS(CH), .WIDTH(W), .DT_WIDTH(DW),
    .LOAD_MODE(0), .NEGATE_OUTPUT(0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
    .period_i(period), .duty_i(duty), .deadtime_i(dt),
    .override_i(ovr), .fault_i(fault), .fault_clear_i(fclr),
    .PWM_o(pwm_a), .sync_o(sync_a), .counter_o(cnt_a),
    .fault_o(flt_a)
  );

  multi_channel_sym_pwm #(
    .CHANNELS(CH), .WIDTH(W), .DT_WIDTH(DW),
    .LOAD_MODE(1), .NEGATE_OUTPUT(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
    .period_i(period), .duty_i(duty), .deadtime_i(dt),
    .override_i(ovr), .fault_i(fault), .fault_clear_i(fclr),
    .PWM_o(pwm_b), .sync_o(sync_b), .counter_o(cnt_b),
    .fault_o(flt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sync();
    int j;
    j = 0;
    step(1);
    while (sync_a !== 1'b1 && j < 400) begin
      step(1);
      j++;
    end
    chk("sync_seen", 32'(sync_a), 1);
  endtask

  task automatic measure(input int n);
    hi0 = 0; lo0 = 0; off0 = 0; both0 = 0;
    hi1 = 0; lo1 = 0; hi2 = 0; lo2 = 0;
    hib = 0; syncs = 0;
    repeat (n) begin
      step(1);
      hi0 += int'(pwm_a[0]);
      lo0 += int'(pwm_a[1]);
      off0 += int'(!pwm_a[0] && !pwm_a[1]);
      both0 += int'(pwm_a[0] && pwm_a[1]);
      hi1 += int'(pwm_a[2]);
      lo1 += int'(pwm_a[3]);
      hi2 += int'(pwm_a[4]);
      lo2 += int'(pwm_a[5]);
      hib += int'(!pwm_b[0]);
      syncs += int'(sync_a);
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_pwm_a", 32'(pwm_a), 0);
    chk("rst_pwm_b", 32'(pwm_b), 32'h3F);
    chk("rst_sync", 32'(sync_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    chk("rst_fault", 32'(flt_a), 0);

    // first cycle after release is a valley
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_sync", 32'(sync_a), 1);
    chk("rel_cnt", 32'(cnt_a), 0);
    step(1);
    chk("cnt_1", 32'(cnt_a), 1);
    chk("sync_low", 32'(sync_a), 0);

    // dt=0, duty 50/0/200 at P=100
    wait_sync();
    measure(200);
    chk("dt0_hi0", hi0, 100);
    chk("dt0_lo0", lo0, 100);
    chk("dt0_both", both0, 0);
    chk("duty0_hi1", hi1, 0);
    chk("duty0_lo1", lo1, 200);
    chk("dutymax_hi2", hi2, 200);
    chk("dutymax_lo2", lo2, 0);
    chk("neg_hib", hib, 100);
    chk("sync_cnt", syncs, 1);

    // dt=10
    dt = 8'd10;
    wait_sync();
    wait_sync();
    measure(200);
    chk("dt10_hi0", hi0, 90);
    chk("dt10_lo0", lo0, 90);
    chk("dt10_off0", off0, 20);
    chk("dt10_both", both0, 0);

    // edge latency on the down slope
    wait_sync();
    step(100);
    chk("peak_cnt", 32'(cnt_a), 100);
    step(61);
    chk("lat_gap", 32'(pwm_a[1:0]), 0);
    step(1);
    chk("lat_hi_on", 32'(pwm_a[1:0]), 1);

    // narrow pulse swallowed
    duty[15:0] = 16'd3;
    wait_sync();
    wait_sync();
    measure(200);
    chk("narrow_hi0", hi0, 0);
    chk("narrow_lo0", lo0, 184);
    chk("narrow_both", both0, 0);

    // mid-period duty change
    dt = 8'd0;
    duty[15:0] = 16'd50;
    wait_sync();
    wait_sync();
    step(20);
    chk("cnt_20", 32'(cnt_a), 20);
    duty[15:0] = 16'd80;
    step(40);
    chk("chg_a_up_old", 32'(pwm_a[1:0]), 2);
    chk("chg_b_up_old", 32'(pwm_b[1:0]), 1);
    step(70);
    chk("chg_a_dn_old", 32'(pwm_a[1:0]), 2);
    chk("chg_b_dn_new", 32'(pwm_b[1:0]), 2);
    step(70);
    chk("chg_valley", 32'(sync_a), 1);
    step(70);
    chk("chg_a_up_new", 32'(pwm_a[1:0]), 1);

    // fault trip, ignored clear, real clear, resume
    duty[15:0] = 16'd50;
    dt = 8'd10;
    wait_sync();
    wait_sync();
    step(100);
    fault = 1'b1;
    step(1);
    chk("flt_set", 32'(flt_a), 1);
    chk("flt_pwm_a", 32'(pwm_a), 0);
    chk("flt_pwm_b", 32'(pwm_b), 32'h3F);
    fclr = 1'b1;
    step(1);
    chk("flt_clr_ign", 32'(flt_a), 1);
    fault = 1'b0;
    step(1);
    chk("flt_cleared", 32'(flt_a), 0);
    chk("flt_still_off", 32'(pwm_a), 0);
    fclr = 1'b0;
    k = 0;
    while (pwm_a[1:0] == 2'b00 && k < 40) begin
      step(1);
      k++;
    end
    chk("resume_delay", k, 10);
    chk("resume_pwm", 32'(pwm_a), 32'h1A);

    // enable and override
    en = 1'b0;
    step(1);
    chk("dis_pwm", 32'(pwm_a), 0);
    ovr = 6'b000001;
    step(1);
    chk("ovr_hi_a", 32'(pwm_a), 1);
    chk("ovr_hi_b", 32'(pwm_b), 32'h3E);
    ovr = 6'b000011;
    step(1);
    chk("ovr_lock", 32'(pwm_a), 0);
    ovr = 6'b000010;
    step(1);
    chk("ovr_lo", 32'(pwm_a), 2);
    fault = 1'b1;
    step(1);
    chk("ovr_fault", 32'(pwm_a), 0);
    fault = 1'b0;
    fclr = 1'b1;
    ovr = '0;
    en = 1'b1;
    step(1);
    fclr = 1'b0;

    // period change waits for the valley
    wait_sync();
    step(50);
    chk("per_cnt50", 32'(cnt_a), 50);
    period = 16'd10;
    step(50);
    chk("per_old_peak", 32'(cnt_a), 100);
    step(100);
    chk("per_valley", 32'(sync_a), 1);
    step(10);
    chk("per_new_peak", 32'(cnt_a), 10);
    step(1);
    chk("per_turn", 32'(cnt_a), 9);

    // period below 2 clamps to 2
    period = 16'd0;
    wait_sync();
    step(1);
    chk("min_c1", 32'(cnt_a), 1);
    step(1);
    chk("min_c2", 32'(cnt_a), 2);
    step(1);
    chk("min_c3", 32'(cnt_a), 1);
    step(1);
    chk("min_c4", 32'(cnt_a), 0);
    chk("min_sync", 32'(sync_a), 1);

    // asynchronous reset mid-operation
    period = 16'd100;
    fault = 1'b1;
    step(1);
    fault = 1'b0;
    chk("pre_rst_flt", 32'(flt_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pwm_a", 32'(pwm_a), 0);
    chk("mid_rst_pwm_b", 32'(pwm_b), 32'h3F);
    chk("mid_rst_cnt", 32'(cnt_a), 0);
    chk("mid_rst_flt", 32'(flt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerel_sync", 32'(sync_a), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
